// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM encoding and frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle of the UART receiver; the receiver takes the slave side.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 i_Rx_Serial;
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;

  modport master (output i_Rx_Serial, input o_Rx_DV, input o_Rx_Byte);
  modport slave  (input i_Rx_Serial, output o_Rx_DV, output o_Rx_Byte);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the synchronized line, samples each bit at its centre,
// and strobes o_Rx_DV for one cycle per frame whose stop bit is valid.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic     i_Clock,
  input  logic     i_Reset,
  uart_rx_if.slave rx
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int                IDX_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state_q,   state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] byte_q,    byte_d;
  logic                 dv_q,      dv_d;

  sync_2ff #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk (i_Clock),
    .rst (i_Reset),
    .d   (rx.i_Rx_Serial),
    .q   (rx_s)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (rx_s != IDLE_LEVEL) state_d = START;
      end

      START: begin
        if (clk_cnt_q == HALF) begin
          clk_cnt_d = '0;
          // A start bit that is gone by its centre was a glitch.
          state_d   = (rx_s != IDLE_LEVEL) ? DATA : IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_IDX) state_d   = STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          state_d   = CLEANUP;
          // A low stop bit is a framing error: the byte is dropped silently.
          if (rx_s == STOP_LEVEL) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      CLEANUP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_Reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
    end
  end

  assign rx.o_Rx_DV   = dv_q;
  assign rx.o_Rx_Byte = byte_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: two receivers (87 and 4 clocks per bit) checked against
// per-receiver scoreboards of expected bytes.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB_A = 87;
  localparam int CPB_B = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_if if_a ();
  uart_rx_if if_b ();

  uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .i_Clock (clk),
    .i_Reset (rst),
    .rx      (if_a.slave)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .i_Clock (clk),
    .i_Reset (rst),
    .rx      (if_b.slave)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int         dv_cnt_a = 0;
  int         dv_cnt_b = 0;
  logic       prev_dv_a = 1'b0;
  logic       prev_dv_b = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) if_b.i_Rx_Serial = v;
    else     if_a.i_Rx_Serial = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] data, input logic stop_lvl,
                      input int start_len, input int stop_len);
    int cpb;
    cpb = sel ? CPB_B : CPB_A;
    drive(sel, 1'b0);
    repeat (start_len) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, data[i]);
      repeat (cpb) @(negedge clk);
    end
    drive(sel, stop_lvl);
    repeat (stop_len) @(negedge clk);
    drive(sel, 1'b1);
  endtask

  task automatic wait_drain(input bit sel, input int budget, input string tag);
    int n;
    n = 0;
    while (((sel ? exp_b.size() : exp_a.size()) != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, sel ? exp_b.size() : exp_a.size(), 0);
  endtask

  // Scoreboard monitors: sample away from the active edge, pop one expected byte per DV.
  initial forever begin
    @(negedge clk);
    if (rst !== 1'b0) begin
      prev_dv_a = 1'b0;
    end else begin
      if (if_a.o_Rx_DV === 1'b1) begin
        dv_cnt_a++;
        check("a_dv_one_cycle", prev_dv_a, 0);
        if (exp_a.size() == 0) check("a_spurious_dv", if_a.o_Rx_DV, 0);
        else                   check("a_byte", if_a.o_Rx_Byte, exp_a.pop_front());
      end
      prev_dv_a = if_a.o_Rx_DV;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst !== 1'b0) begin
      prev_dv_b = 1'b0;
    end else begin
      if (if_b.o_Rx_DV === 1'b1) begin
        dv_cnt_b++;
        check("b_dv_one_cycle", prev_dv_b, 0);
        if (exp_b.size() == 0) check("b_spurious_dv", if_b.o_Rx_DV, 0);
        else                   check("b_byte", if_b.o_Rx_Byte, exp_b.pop_front());
      end
      prev_dv_b = if_b.o_Rx_DV;
    end
  end

  initial begin
    rst              = 1'b1;
    if_a.i_Rx_Serial = 1'b1;
    if_b.i_Rx_Serial = 1'b1;

    // Power-up reset held while the line wiggles.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("rst_dv_a",   if_a.o_Rx_DV,   0);
      check("rst_byte_a", if_a.o_Rx_Byte, 8'h00);
      check("rst_dv_b",   if_b.o_Rx_DV,   0);
      check("rst_byte_b", if_b.o_Rx_Byte, 8'h00);
      if (i < 5) begin
        if_a.i_Rx_Serial = 1'($urandom_range(0, 1));
        if_b.i_Rx_Serial = 1'($urandom_range(0, 1));
      end else begin
        if_a.i_Rx_Serial = 1'b1;
        if_b.i_Rx_Serial = 1'b1;
      end
    end
    check("rst_state_a", 32'(dut_a.state_q), 32'(IDLE));
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Back-to-back frames, stretched start bit.
    exp_a.push_back(8'h3F);
    exp_a.push_back(8'h3A);
    send(0, 8'h3F, 1'b1, 88, 87);
    send(0, 8'h3A, 1'b1, 88, 87);
    wait_drain(0, 2000, "b2b_drain");
    repeat (200) @(negedge clk);
    check("b2b_dv_count", dv_cnt_a, 2);
    check("b2b_last_byte", if_a.o_Rx_Byte, 8'h3A);

    // Short low glitch is rejected.
    drive(0, 1'b0);
    repeat (20) @(negedge clk);
    drive(0, 1'b1);
    repeat (100) @(negedge clk);
    check("glitch_state", 32'(dut_a.state_q), 32'(IDLE));
    check("glitch_dv_count", dv_cnt_a, 2);
    exp_a.push_back(8'hA5);
    send(0, 8'hA5, 1'b1, 87, 87);
    wait_drain(0, 2000, "a5_drain");
    repeat (100) @(negedge clk);
    check("a5_dv_count", dv_cnt_a, 3);

    // Framing error: stop bit low.
    send(0, 8'h55, 1'b0, 87, 87);
    repeat (300) @(negedge clk);
    check("ferr_dv_count", dv_cnt_a, 3);
    check("ferr_byte_hold", if_a.o_Rx_Byte, 8'hA5);
    check("ferr_state", 32'(dut_a.state_q), 32'(IDLE));

    // Reset pulse in the middle of data bit 4 of 8'hF6 (bits 4..7 high).
    drive(0, 1'b0);
    repeat (87) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(0, (i == 1) || (i == 2));
      repeat (87) @(negedge clk);
    end
    drive(0, 1'b1);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (47 + 4 * 87 + 100) @(negedge clk);
    check("rst_mid_dv_count", dv_cnt_a, 3);
    check("rst_mid_byte", if_a.o_Rx_Byte, 8'h00);
    exp_a.push_back(8'hC3);
    send(0, 8'hC3, 1'b1, 87, 87);
    wait_drain(0, 2000, "c3_drain");
    repeat (100) @(negedge clk);
    check("c3_dv_count", dv_cnt_a, 4);

    // Minimum oversampling ratio, back to back.
    exp_b.push_back(8'h00);
    exp_b.push_back(8'hFF);
    exp_b.push_back(8'h81);
    send(1, 8'h00, 1'b1, CPB_B, CPB_B);
    send(1, 8'hFF, 1'b1, CPB_B, CPB_B);
    send(1, 8'h81, 1'b1, CPB_B, CPB_B);
    wait_drain(1, 200, "b_drain");
    repeat (50) @(negedge clk);
    check("b_dv_count", dv_cnt_b, 3);
    check("b_last_byte", if_b.o_Rx_Byte, 8'h81);
    check("a_final_dv_count", dv_cnt_a, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
